// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter between two masters that share one memory port.
//   Master A is the processor memory port and master B is the DMA/debug
//   loader. One access runs at a time. The arbiter waits for iMemRdy, then
//   returns read data to the granted master together with a one-cycle
//   completion pulse.
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN):
//   An access that stays in ACCESS for TIMEOUT_CYCLES cycles without
//   iMemRdy is aborted, and the granted oXErr pulses instead of oXRdy.
//   When the macro is not defined, oAErr and oBErr are tied to 0.
//
// Ports:
//   iClk, iRst                          clock, synchronous active-high reset
//   iXReq/iXWrite/iXAddr/iXData         master X request (X = A, B)
//   oXData/oXRdy/oXErr                  master X read data, done pulse, timeout pulse
//   oMemAddr/oMemData/oMemRead/oMemWrite  memory request
//   iMemData/iMemRdy                    memory read data, completion
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iAReq,
  input  logic              iAWrite,
  input  logic [ADDR_W-1:0] iAAddr,
  input  logic [DATA_W-1:0] iAData,
  output logic [DATA_W-1:0] oAData,
  output logic              oARdy,
  output logic              oAErr,
  input  logic              iBReq,
  input  logic              iBWrite,
  input  logic [ADDR_W-1:0] iBAddr,
  input  logic [DATA_W-1:0] iBData,
  output logic [DATA_W-1:0] oBData,
  output logic              oBRdy,
  output logic              oBErr,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  input  logic [DATA_W-1:0] iMemData,
  output logic              oMemRead,
  output logic              oMemWrite,
  input  logic              iMemRdy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            r_state;
  logic              r_last_b;   // 1 when B held the most recent grant
  logic              r_grant_b;  // owner of the current access
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [DATA_W-1:0] r_a_data;
  logic [DATA_W-1:0] r_b_data;
  logic              r_a_rdy;
  logic              r_b_rdy;

  // B wins when it is the only requester, or on a tie when A went last
  logic w_pick_b;
  assign w_pick_b = iBReq && (!iAReq || !r_last_b);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a_err;
  logic             r_b_err;
  // Counter holds completed ACCESS cycles; this edge ends the last one allowed
  logic             w_timeout;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign oAErr = r_a_err;
  assign oBErr = r_b_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^32'(TIMEOUT_CYCLES);
  assign oAErr = 1'b0;
  assign oBErr = 1'b0;
`endif

  // Arbitration FSM with registered outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= S_IDLE;
      r_last_b   <= 1'b1;
      r_grant_b  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_a_data   <= '0;
      r_b_data   <= '0;
      r_a_rdy    <= 1'b0;
      r_b_rdy    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_a_err    <= 1'b0;
      r_b_err    <= 1'b0;
`endif
    end else begin
      // Completion pulses last only for the single DONE cycle
      r_a_rdy <= 1'b0;
      r_b_rdy <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_a_err <= 1'b0;
      r_b_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (iAReq || iBReq) begin
            r_grant_b  <= w_pick_b;
            r_last_b   <= w_pick_b;
            r_mem_addr <= w_pick_b ? iBAddr : iAAddr;
            r_mem_data <= w_pick_b ? iBData : iAData;
            r_mem_rd   <= w_pick_b ? !iBWrite : !iAWrite;
            r_mem_wr   <= w_pick_b ? iBWrite : iAWrite;
`ifdef MEM_ARB_TIMEOUT_EN
            r_cnt      <= '0;
`endif
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (iMemRdy) begin
            if (r_mem_rd) begin
              if (r_grant_b) r_b_data <= iMemData;
              else           r_a_data <= iMemData;
            end
            r_b_rdy  <= r_grant_b;
            r_a_rdy  <= !r_grant_b;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_state  <= S_DONE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (w_timeout) begin
            r_b_err  <= r_grant_b;
            r_a_err  <= !r_grant_b;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oMemAddr  = r_mem_addr;
  assign oMemData  = r_mem_data;
  assign oMemRead  = r_mem_rd;
  assign oMemWrite = r_mem_wr;
  assign oAData    = r_a_data;
  assign oBData    = r_b_data;
  assign oARdy     = r_a_rdy;
  assign oBRdy     = r_b_rdy;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-master arbiter sharing the processor's single memory port (address, write data, read data, read/write strobes, ready) between master A (PROCESSOR memory port) and master B (DMA/debug loader). It grants one access at a time with round-robin priority and waits on the memory ready handshake. It returns read data and a one-cycle completion pulse to the granted master.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 255, cycles in ACCESS before abort (used only with the optional feature)

Ports:
iClk  in  1  clock, all logic on rising edge
iRst  in  1  synchronous active-high reset
iAReq  in  1  master A request, held until oARdy
iAWrite  in  1  A: 1 = write, 0 = read
iAAddr  in  ADDR_W  A address
iAData  in  DATA_W  A write data
oAData  out  DATA_W  A read data, valid with oARdy
oARdy  out  1  A completion pulse
oAErr  out  1  A timeout pulse
iBReq, iBWrite, iBAddr, iBData, oBData, oBRdy, oBErr  same as A, for master B
oMemAddr  out  ADDR_W  memory address
oMemData  out  DATA_W  memory write data
iMemData  in  DATA_W  memory read data
oMemRead  out  1  read strobe
oMemWrite  out  1  write strobe
iMemRdy  in  1  memory ready/complete

Behaviour:
- Reset (iRst=1 at edge): state IDLE; all outputs 0; last-grant pointer = B, so A wins the first tie. Reset asserted mid-access drops strobes at that edge. No Rdy/Err pulse is issued.
- States: IDLE, ACCESS, DONE.
- IDLE, no request: stay; strobes 0.
- IDLE, one request: grant that master.
- IDLE, both requesting: grant the master not granted last (round-robin).
- On grant, at that edge: register addr, data and write for the winner; set oMemRead = ~write and oMemWrite = write; update the last-grant pointer; go to ACCESS.
- ACCESS: memory outputs held stable from registers; master inputs are ignored.
- ACCESS with iMemRdy=1 at an edge: capture iMemData into the granted oXData (reads only; unchanged on writes); drop strobes; pulse the granted oXRdy for exactly one cycle; go to DONE.
- ACCESS with iMemRdy=0: stay. Wait is unbounded without the optional feature.
- DONE: oXRdy=1 for this cycle; requests are ignored; go to IDLE next edge. This gives the master a cycle to drop or change its request, so the same request is never re-granted.
- Latency: request sampled at edge 0 → strobes high after edge 0. If iMemRdy=1 during that cycle, oXRdy is high after edge 1. Minimum back-to-back period is 3 cycles per access.
- Only one of oMemRead/oMemWrite is high at a time. Both are 0 outside ACCESS.
- oXData holds its last value until the next read completion for that master.
- A request dropped by a master before grant is simply not served. A request dropped during ACCESS has no effect: the access completes.
- iMemRdy in IDLE or DONE is ignored.

Optional Feature:
Macro MEM_ARB_TIMEOUT_EN.
- With the macro: an 8..16-bit counter clears on entry to ACCESS and increments each ACCESS cycle. When it reaches TIMEOUT_CYCLES without iMemRdy:
  - strobes drop;
  - the granted oXErr pulses one cycle (in DONE) instead of oXRdy;
  - oXData is unchanged;
  - the state goes to DONE.
- Without the macro: no counter; oAErr/oBErr are tied to 0.

Test Plan:
- Reset, then A read 0x1000 with iMemRdy=1 and iMemData=0x2 → oMemRead high for 1 cycle, oARdy pulses 2 cycles after request, oAData=0x2.
- A write 0x1004 data 0x1 with iMemRdy delayed 3 cycles → oMemWrite held 4 cycles with oMemAddr=0x1004 and oMemData=0x1, then a single oARdy pulse; oAData is unchanged.
- A and B request simultaneously from reset, both held → grant order A, B, A, B; each oXRdy is separated by 3 cycles with zero-wait memory.
- B holds its request continuously and A requests once → A is served immediately after the current B access; B is not starved afterward.
- iRst asserted during ACCESS → strobes 0 after the next edge, no Rdy pulse, next grant goes to A.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, iMemRdy held 0 → strobes drop after 4 ACCESS cycles, oAErr pulses once, oARdy stays 0.
